// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RISC-V pipeline.
// Issues loads/stores over a req/ready handshake, stalls upstream on wait
// states, formats load data and store lanes, and holds the MEM/WB register.
// Optional build macro: MISALIGN_CHECK_EN adds misaligned-access detection
// and the wb_misalign output.
module mem_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_funct3,
  output logic              stall_o,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ready,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_alu_result,
  output logic [XLEN-1:0]   wb_mem_data,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write
`ifdef MISALIGN_CHECK_EN
  ,
  output logic              wb_misalign
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;

  logic [1:0]      lane;
  logic            is_byte;
  logic            is_half;
  logic            is_load;
  logic            is_store;
  logic            misaligned;
  logic            mem_access;
  logic            mem_op;
  logic            req_int;
  logic [3:0]      store_be;
  logic [XLEN-1:0] store_wdata;
  logic [XLEN-1:0] byte_shifted;
  logic [XLEN-1:0] half_shifted;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;

  // Access size comes from funct3[1:0]; anything wider than a half is a word.
  assign lane       = in_alu_result[1:0];
  assign is_byte    = (in_funct3[1:0] == 2'b00);
  assign is_half    = (in_funct3[1:0] == 2'b01);
  // A slot with both read and write set is handled as a load.
  assign is_load    = in_mem_read;
  assign is_store   = in_mem_write & ~in_mem_read;
  assign mem_access = in_valid & (in_mem_read | in_mem_write);

`ifdef MISALIGN_CHECK_EN
  logic is_word;
  assign is_word    = ~is_byte & ~is_half;
  assign misaligned = mem_access & ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Misaligned accesses never reach the memory bus.
  assign mem_op = mem_access & ~misaligned;

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and request generation: BUSY keeps requesting until ready.
  always_comb begin
    state_next = state;
    req_int    = 1'b0;
    case (state)
      IDLE: begin
        req_int = mem_op;
        if (mem_op && !dmem_ready) state_next = BUSY;
      end
      BUSY: begin
        req_int = 1'b1;
        if (dmem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request is also masked by reset so it drops the instant rst_n falls.
  assign dmem_req   = req_int & rst_n;
  assign stall_o    = dmem_req & ~dmem_ready;
  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = {in_alu_result[XLEN-1:2], 2'b00};
  assign dmem_be    = store_be;
  assign dmem_wdata = store_wdata;

  // Store lane steering: replicate narrow data across the word, enable lanes.
  always_comb begin
    store_be    = 4'b0000;
    store_wdata = in_store_data;
    if (is_store) begin
      if (is_byte) begin
        store_be    = 4'b0001 << lane;
        store_wdata = {4{in_store_data[7:0]}};
      end else if (is_half) begin
        store_be    = 4'b0011 << {lane[1], 1'b0};
        store_wdata = {2{in_store_data[15:0]}};
      end else begin
        store_be    = 4'b1111;
      end
    end
  end

  assign byte_shifted = dmem_rdata >> {lane, 3'b000};
  assign half_shifted = dmem_rdata >> {lane[1], 4'b0000};
  assign load_byte    = byte_shifted[7:0];
  assign load_half    = half_shifted[15:0];

  // Load extraction: funct3[2] selects zero extension.
  always_comb begin
    load_data = dmem_rdata;
    if (is_byte) begin
      load_data = in_funct3[2] ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
    end else if (is_half) begin
      load_data = in_funct3[2] ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
    end
  end

  // MEM/WB register: a stalled cycle inserts a bubble downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      wb_mem_to_reg <= 1'b0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      wb_misalign   <= 1'b0;
`endif
    end else begin
      wb_alu_result <= in_alu_result;
      wb_mem_to_reg <= in_mem_to_reg;
      wb_rd         <= in_rd;
      wb_mem_data   <= (in_valid & is_load & ~misaligned) ? load_data : '0;
      if (stall_o) begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
`ifdef MISALIGN_CHECK_EN
        wb_misalign  <= 1'b0;
`endif
      end else begin
        wb_valid     <= in_valid;
        wb_reg_write <= in_valid & in_reg_write & ~misaligned;
`ifdef MISALIGN_CHECK_EN
        wb_misalign  <= misaligned;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage with an
// arithmetic reference model of load/store formatting and wait-state timing.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_store_data = '0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic        in_mem_to_reg = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic        stall_o;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ready = 1'b0;
  logic        wb_valid;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_mem_data;
  logic        wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
`ifdef MISALIGN_CHECK_EN
  logic        wb_misalign;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .in_funct3(in_funct3), .stall_o(stall_o), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
    .wb_mem_data(wb_mem_data), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write)
`ifdef MISALIGN_CHECK_EN
    , .wb_misalign(wb_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // One instruction through the stage; waits = memory wait cycles before ready.
  task automatic do_txn(input logic valid, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                        input logic m2r, input logic [2:0] f3, input logic [31:0] rdata,
                        input int waits);
    logic        acc, load, store, mis, issue;
    int          sz, n;
    logic [31:0] exp_be, exp_wd, exp_ld, v;
    acc   = valid && (mr || mw);
    load  = mr;
    store = mw && !mr;
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis   = 1'b0;
`ifdef MISALIGN_CHECK_EN
    mis   = acc && ((sz == 2 && alu[0]) || (sz == 4 && alu[1:0] != 2'b00));
`endif
    issue = acc && !mis;
    n     = issue ? waits : 0;
    exp_be = 0;
    exp_wd = sd;
    if (store) begin
      if (sz == 1) begin
        exp_be = 32'd1 << alu[1:0];
        exp_wd = (sd & 32'hFF) * 32'h0101_0101;
      end else if (sz == 2) begin
        exp_be = 32'd3 << (2 * alu[1]);
        exp_wd = (sd & 32'hFFFF) * 32'h0001_0001;
      end else begin
        exp_be = 32'hF;
      end
    end
    if (sz == 1) begin
      v = (rdata >> (8 * alu[1:0])) & 32'hFF;
      if (!f3[2] && v >= 128) v = v + 32'hFFFF_FF00;
      exp_ld = v;
    end else if (sz == 2) begin
      v = (rdata >> (16 * alu[1])) & 32'hFFFF;
      if (!f3[2] && v >= 32768) v = v + 32'hFFFF_0000;
      exp_ld = v;
    end else begin
      exp_ld = rdata;
    end
    for (int w = 0; w <= n; w++) begin
      @(negedge clk);
      in_valid = valid; in_alu_result = alu; in_store_data = sd; in_rd = rd;
      in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
      in_mem_to_reg = m2r; in_funct3 = f3;
      if (issue) dmem_ready = (w == n);
      else       dmem_ready = 1'($urandom_range(0, 1));
      dmem_rdata = (w == n) ? rdata : $urandom;
      #1;
      chk("req", dmem_req, issue);
      chk("stall", stall_o, issue && (w < n));
      if (issue) begin
        chk("addr", dmem_addr, {alu[31:2], 2'b00});
        chk("we", dmem_we, store);
        chk("be", dmem_be, exp_be);
        if (store) chk("wdata", dmem_wdata, exp_wd);
      end
      @(posedge clk);
      #1;
      if (w < n) begin
        chk("bubble_valid", wb_valid, 0);
        chk("bubble_rw", wb_reg_write, 0);
      end else begin
        chk("wb_valid", wb_valid, valid);
        chk("wb_reg_write", wb_reg_write, valid && rw && !mis);
        chk("wb_alu", wb_alu_result, alu);
        chk("wb_rd", wb_rd, rd);
        chk("wb_m2r", wb_mem_to_reg, m2r);
        chk("wb_mem_data", wb_mem_data, (valid && load && !mis) ? exp_ld : 0);
`ifdef MISALIGN_CHECK_EN
        chk("wb_misalign", wb_misalign, mis);
`endif
      end
    end
  endtask

  initial begin
    // Reset state, with a load presented so the request mask is exercised.
    in_valid = 1'b1; in_mem_read = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    in_valid = 1'b0; in_mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    do_txn(1, 32'hAAAA_AAAA, 0, 5, 1, 0, 0, 0, 3'b000, 0, 0);
    chk("alu_const", wb_alu_result, 32'hAAAA_AAAA);
    do_txn(1, 32'h0000_1003, 0, 7, 1, 1, 0, 1, 3'b000, 32'h8000_0000, 0);
    chk("lb_const", wb_mem_data, 32'hFFFF_FF80);
    do_txn(1, 32'h0000_1003, 0, 7, 1, 1, 0, 1, 3'b100, 32'h8000_0000, 0);
    chk("lbu_const", wb_mem_data, 32'h0000_0080);
    do_txn(1, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 0, 1, 0, 3'b001, 0, 0);
    do_txn(1, 32'h0000_3000, 0, 9, 1, 1, 0, 1, 3'b010, 32'hDEAD_BEEF, 3);
    chk("lw_wait_const", wb_mem_data, 32'hDEAD_BEEF);
    do_txn(1, 32'h0000_4001, 0, 3, 1, 1, 1, 1, 3'b010, 32'h1234_5678, 1);
`ifdef MISALIGN_CHECK_EN
    do_txn(1, 32'h0000_0001, 0, 4, 1, 1, 0, 1, 3'b010, 32'h1111_1111, 2);
    chk("misalign_const", wb_misalign, 1);
`endif

    // Randomized instruction mix.
    for (int i = 0; i < 300; i++) begin
      int          kind;
      logic        v, mr, mw;
      logic [2:0]  f3;
      kind = $urandom_range(0, 3);
      v    = ($urandom_range(0, 7) != 0);
      mr   = (kind == 1) || (kind == 3);
      mw   = (kind == 2) || (kind == 3);
      f3   = (kind == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      do_txn(v, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)), mr, mw,
             1'($urandom_range(0, 1)), f3, $urandom, $urandom_range(0, 3));
    end

    // Asynchronous reset while a load is waiting in BUSY.
    @(negedge clk);
    in_valid = 1'b1; in_alu_result = 32'h0000_5008; in_mem_read = 1'b1;
    in_mem_write = 1'b0; in_funct3 = 3'b010; in_rd = 5'd6; in_reg_write = 1'b1;
    in_mem_to_reg = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("busy_req", dmem_req, 1);
    @(posedge clk);
    #2;
    chk("busy_hold_req", dmem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", dmem_req, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_wb_alu", wb_alu_result, 0);
    chk("arst_wb_rd", wb_rd, 0);
    chk("arst_wb_m2r", wb_mem_to_reg, 0);
    chk("arst_wb_rw", wb_reg_write, 0);
    chk("arst_wb_data", wb_mem_data, 0);
    @(negedge clk);
    in_valid = 1'b0; in_mem_read = 1'b0; in_reg_write = 1'b0; dmem_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", dmem_req, 0);
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    chk("post_rst_idle_req", dmem_req, 0);
    chk("post_rst_stall", stall_o, 0);
    @(posedge clk);
    #1;
    chk("post_rst_wb_valid", wb_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline, between the EX/MEM register and the write-back mux.
- Issues loads and stores to the data memory over a req/ready handshake and stalls the pipeline on wait states.
- Formats load data (byte/half/word, signed/unsigned) and computes store byte enables.
- Registers the MEM/WB pipeline outputs that feed the write-back stage (alu result, memory data, mem_to_reg select, rd, reg_write).

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-index width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  EX/MEM slot holds a real instruction.
- in_alu_result  input  32  ALU result / effective address.
- in_store_data  input  32  rs2 value for stores.
- in_rd  input  5  destination register.
- in_reg_write  input  1  instruction writes rd.
- in_mem_read  input  1  load.
- in_mem_write  input  1  store.
- in_mem_to_reg  input  1  write-back selects memory data.
- in_funct3  input  3  access size and sign.
- stall_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- dmem_req  output  1  memory request.
- dmem_we  output  1  1 = store.
- dmem_addr  output  32  word-aligned address {in_alu_result[31:2],2'b00}.
- dmem_wdata  output  32  lane-aligned store data.
- dmem_be  output  4  store byte enables; 0000 for loads.
- dmem_rdata  input  32  load word, valid when dmem_ready.
- dmem_ready  input  1  request accepted/completed this cycle.
- wb_valid  output  1  MEM/WB slot valid.
- wb_alu_result  output  32  registered in_alu_result.
- wb_mem_data  output  32  registered formatted load data; 0 for non-loads.
- wb_mem_to_reg  output  1  registered in_mem_to_reg.
- wb_rd  output  5  registered in_rd.
- wb_reg_write  output  1  registered in_reg_write AND valid.

Behaviour:
- Reset: state IDLE; all wb_* = 0; dmem_req forced 0 while rst_n low.
- FSM states: IDLE, BUSY.
- mem_op = in_valid & (in_mem_read | in_mem_write).
- dmem_req = (IDLE & mem_op) | BUSY.
- stall_o = dmem_req & ~dmem_ready.
- IDLE, mem_op, dmem_ready=1: complete in the same cycle, latch into MEM/WB, stay IDLE.
- IDLE, mem_op, dmem_ready=0: go to BUSY. BUSY holds dmem_req until dmem_ready, then latches and returns to IDLE.
- Upstream holds the EX/MEM inputs stable while stall_o=1. The stage relies on this and does not capture them internally.
- While stalled, MEM/WB loads a bubble: wb_valid=0, wb_reg_write=0. Other wb_* fields are don't-care but still update.
- Non-memory instructions and bubbles pass in 1 cycle. Latency is 1 cycle plus N memory wait cycles.
- in_mem_read and in_mem_write both set: treat as a load; dmem_we=0.
- Load formatting, lane = addr[1:0]:
  - 000 LB: sign-extend byte at lane.
  - 001 LH: sign-extend half at addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other funct3 values: LW.
- Store formatting:
  - SB: be = 0001<<lane; wdata = byte replicated 4 times.
  - SH: be = 0011<<{addr[1],0}; wdata = half replicated twice.
  - SW: be = 1111.
- Async reset during BUSY: return to IDLE immediately and drop dmem_req. A late dmem_ready is ignored.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- With the macro:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, is misaligned.
  - A misaligned access issues no dmem_req and does not stall.
  - It completes in 1 cycle with wb_reg_write=0 and the added output port wb_misalign=1 (reset 0, otherwise 0).
- Without the macro: no wb_misalign port. Low address bits below the access size are ignored for lane selection.

Test Plan:
- ALU op, in_alu_result=AAAA_AAAA, rd=5, reg_write=1, no mem -> next edge: wb_valid=1, wb_alu_result=AAAA_AAAA, wb_rd=5, wb_mem_data=0, stall_o never 1.
- LB addr=0000_1003, dmem_rdata=8000_0000, ready same cycle -> wb_mem_data=FFFF_FF80, wb_mem_to_reg=1; LBU same -> 0000_0080.
- SH addr=0000_2002, store_data=0000_BEEF -> dmem_we=1, dmem_addr=0000_2000, be=1100, wdata=BEEF_BEEF.
- LW with dmem_ready low 3 cycles, rdata=DEAD_BEEF -> stall_o=1 for 3 cycles, 3 bubbles (wb_valid=0), then wb_mem_data=DEAD_BEEF.
- rst_n pulled low during BUSY wait -> dmem_req=0 and all wb_*=0 immediately; after release with in_valid=0, stays IDLE.
- MISALIGN_CHECK_EN: LW addr=0000_0001 -> no dmem_req, wb_misalign=1, wb_reg_write=0.
